// File: rtl/enc8_3_queued.sv
// Queued 8-to-3 priority encoder: rising edges on i7..i0 are held as
// pending events and presented one index at a time over valid/ready.
module enc8_3_queued (
   input  logic clk,
   input  logic rst_n,
   input  logic i7,
   input  logic i6,
   input  logic i5,
   input  logic i4,
   input  logic i3,
   input  logic i2,
   input  logic i1,
   input  logic i0,
   input  logic ready,
   output logic a,
   output logic b,
   output logic c,
   output logic valid,
   output logic ovf,
   output logic idle
);

   typedef enum logic {
      S_IDLE,
      S_HOLD
   } state_t;

   state_t     r_state;
   state_t     w_state_nx;
   logic [7:0] r_prev;
   logic [7:0] r_pend;
   logic [2:0] r_code;
   logic       r_ovf;
   logic [2:0] w_code_nx;
   logic [7:0] w_in;
   logic [7:0] w_edge;
   logic [7:0] w_clr;
   logic [7:0] w_rem;
   logic [7:0] w_pend_nx;
   logic       w_ovf_nx;

   // highest set bit wins; ascending scan lets the top bit overwrite
   function automatic logic [2:0] f_top(input logic [7:0] v);
      f_top = 3'd0;
      for (int n = 0; n < 8; n++) begin
         if (v[n]) f_top = 3'(n);
      end
   endfunction

   assign w_in   = {i7, i6, i5, i4, i3, i2, i1, i0};
   assign w_edge = w_in & ~r_prev;

   always_comb begin
      w_clr = 8'd0;
      if (r_state == S_HOLD && ready) w_clr = 8'd1 << r_code;
      w_rem     = r_pend & ~w_clr;
      // set wins over clear on the accepted line
      w_pend_nx = w_rem | w_edge;
      w_ovf_nx  = r_ovf | (|(w_edge & w_rem));
   end

   always_comb begin
      w_state_nx = r_state;
      w_code_nx  = r_code;
      unique case (r_state)
         S_IDLE: begin
            if (|r_pend) begin
               w_code_nx  = f_top(r_pend);
               w_state_nx = S_HOLD;
            end
         end
         S_HOLD: begin
            if (ready) begin
               if (|w_rem) w_code_nx  = f_top(w_rem);
               else        w_state_nx = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_code  <= 3'd0;
      end else begin
         r_state <= w_state_nx;
         r_code  <= w_code_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prev <= 8'd0;
         r_pend <= 8'd0;
         r_ovf  <= 1'b0;
      end else begin
         r_prev <= w_in;
         r_pend <= w_pend_nx;
         r_ovf  <= w_ovf_nx;
      end
   end

   assign {a, b, c} = r_code;
   assign valid     = (r_state == S_HOLD);
   assign ovf       = r_ovf;
   assign idle      = (r_pend == 8'd0) && (r_state == S_IDLE);

endmodule

// File: tb/tb_enc8_3_queued.sv
// Bench for enc8_3_queued: directed vector table, then random traffic
// checked against a pending-set model.
module tb_enc8_3_queued;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tb_in;
   logic       ready;
   logic       a, b, c, valid, ovf, idle;

   always #5 clk = ~clk;

   enc8_3_queued dut (
      .clk   (clk),
      .rst_n (rst_n),
      .i7    (tb_in[7]),
      .i6    (tb_in[6]),
      .i5    (tb_in[5]),
      .i4    (tb_in[4]),
      .i3    (tb_in[3]),
      .i2    (tb_in[2]),
      .i1    (tb_in[1]),
      .i0    (tb_in[0]),
      .ready (ready),
      .a     (a),
      .b     (b),
      .c     (c),
      .valid (valid),
      .ovf   (ovf),
      .idle  (idle)
   );

   typedef struct {
      bit       rst_n;
      bit [7:0] in;
      bit       rdy;
      bit       v;
      bit [2:0] code;
      bit       ovf;
      bit       idle;
   } vec_t;

   vec_t tbl[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // model: a set of pending lines plus the code on offer
   int m_pend = 0, m_prev = 0, m_code = 0;
   bit m_v = 0, m_ovf = 0;

   function automatic vec_t mkv(bit r, bit [7:0] in, bit rd, bit ev,
                                int cd, bit o, bit id);
      vec_t t;
      t.rst_n = r;
      t.in    = in;
      t.rdy   = rd;
      t.v     = ev;
      t.code  = 3'(cd);
      t.ovf   = o;
      t.idle  = id;
      return t;
   endfunction

   function automatic int top(int mask);
      for (int n = 7; n >= 0; n--) if (mask[n]) return n;
      return 0;
   endfunction

   task automatic model_step(bit r, int in, bit rd);
      int rises, taken, left;
      rises = in & ~m_prev & 8'hFF;
      taken = (m_v && rd) ? (1 << m_code) : 0;
      left  = m_pend & ~taken;
      if (!r) begin
         m_pend = 0; m_prev = 0; m_code = 0; m_v = 0; m_ovf = 0;
      end else begin
         if ((rises & left) != 0) m_ovf = 1;
         if (!m_v) begin
            if (m_pend != 0) begin
               m_code = top(m_pend);
               m_v = 1;
            end
         end else if (rd) begin
            if (left != 0) m_code = top(left);
            else m_v = 0;
         end
         m_pend = left | rises;
         m_prev = in;
      end
   endtask

   task automatic check(string nm, bit ev, bit [2:0] cd, bit o, bit id);
      n_tests++;
      if (valid !== ev || {a, b, c} !== cd || ovf !== o || idle !== id) begin
         n_fail++;
         $display("FAIL %s: got v=%b code=%b ovf=%b idle=%b, want v=%b code=%b ovf=%b idle=%b",
                  nm, valid, {a, b, c}, ovf, idle, ev, cd, o, id);
      end
   endtask

   task automatic cycle(bit r, bit [7:0] in, bit rd);
      rst_n = r;
      tb_in = in;
      ready = rd;
      model_step(r, int'(in), rd);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      tb_in = 8'h00;
      ready = 1'b0;
      // single event on i2
      tbl.push_back(mkv(0, 8'h00, 1, 0, 0, 0, 1));
      tbl.push_back(mkv(1, 8'h00, 1, 0, 0, 0, 1));
      tbl.push_back(mkv(1, 8'h04, 1, 0, 0, 0, 0));
      tbl.push_back(mkv(1, 8'h04, 1, 1, 2, 0, 0));
      tbl.push_back(mkv(1, 8'h04, 1, 0, 2, 0, 1));
      tbl.push_back(mkv(1, 8'h00, 1, 0, 2, 0, 1));
      // i7,i5,i0 together
      tbl.push_back(mkv(1, 8'hA1, 1, 0, 2, 0, 0));
      tbl.push_back(mkv(1, 8'hA1, 1, 1, 7, 0, 0));
      tbl.push_back(mkv(1, 8'hA1, 1, 1, 5, 0, 0));
      tbl.push_back(mkv(1, 8'hA1, 1, 1, 0, 0, 0));
      tbl.push_back(mkv(1, 8'hA1, 1, 0, 0, 0, 1));
      tbl.push_back(mkv(1, 8'h00, 1, 0, 0, 0, 1));
      // backpressure, i6 arrives while 3 held
      tbl.push_back(mkv(1, 8'h08, 0, 0, 0, 0, 0));
      tbl.push_back(mkv(1, 8'h08, 0, 1, 3, 0, 0));
      tbl.push_back(mkv(1, 8'h48, 0, 1, 3, 0, 0));
      tbl.push_back(mkv(1, 8'h48, 0, 1, 3, 0, 0));
      tbl.push_back(mkv(1, 8'h48, 1, 1, 6, 0, 0));
      tbl.push_back(mkv(1, 8'h48, 1, 0, 6, 0, 1));
      tbl.push_back(mkv(1, 8'h00, 1, 0, 6, 0, 1));
      // overflow on i4
      tbl.push_back(mkv(1, 8'h10, 0, 0, 6, 0, 0));
      tbl.push_back(mkv(1, 8'h00, 0, 1, 4, 0, 0));
      tbl.push_back(mkv(1, 8'h10, 0, 1, 4, 1, 0));
      tbl.push_back(mkv(1, 8'h00, 0, 1, 4, 1, 0));
      tbl.push_back(mkv(1, 8'h00, 1, 0, 4, 1, 1));
      tbl.push_back(mkv(1, 8'h00, 1, 0, 4, 1, 1));
      tbl.push_back(mkv(0, 8'h00, 1, 0, 0, 0, 1));
      // set wins on i1
      tbl.push_back(mkv(1, 8'h02, 1, 0, 0, 0, 0));
      tbl.push_back(mkv(1, 8'h00, 1, 1, 1, 0, 0));
      tbl.push_back(mkv(1, 8'h02, 1, 0, 1, 0, 0));
      tbl.push_back(mkv(1, 8'h02, 1, 1, 1, 0, 0));
      tbl.push_back(mkv(1, 8'h02, 1, 0, 1, 0, 1));
      // reset during hold with 7 and 4 pending
      tbl.push_back(mkv(1, 8'h90, 0, 0, 1, 0, 0));
      tbl.push_back(mkv(1, 8'h90, 0, 1, 7, 0, 0));
      tbl.push_back(mkv(0, 8'h00, 0, 0, 0, 0, 1));
      tbl.push_back(mkv(1, 8'h00, 1, 0, 0, 0, 1));
      tbl.push_back(mkv(1, 8'h00, 1, 0, 0, 0, 1));
      // line high through reset counts once
      tbl.push_back(mkv(0, 8'h01, 1, 0, 0, 0, 1));
      tbl.push_back(mkv(1, 8'h01, 1, 0, 0, 0, 0));
      tbl.push_back(mkv(1, 8'h01, 1, 1, 0, 0, 0));
      tbl.push_back(mkv(1, 8'h01, 1, 0, 0, 0, 1));

      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].rst_n, tbl[i].in, tbl[i].rdy);
         check($sformatf("vec%0d", i), tbl[i].v, tbl[i].code,
               tbl[i].ovf, tbl[i].idle);
      end

      cycle(0, 8'h00, 0);
      check("rnd_reset", m_v, 3'(m_code), m_ovf, (m_pend == 0) && !m_v);
      for (int i = 0; i < 3000; i++) begin
         bit       r;
         bit [7:0] in;
         bit       rd;
         r  = ($urandom_range(0, 199) != 0);
         in = 8'($urandom) & 8'($urandom);
         rd = ($urandom_range(0, 3) != 0);
         cycle(r, in, rd);
         check($sformatf("rnd%0d", i), m_v, 3'(m_code), m_ovf,
               (m_pend == 0) && !m_v);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
